// File: rtl/mips_pkg.sv
// Shared control-word layout and forwarding encodings for the MIPS pipeline.
package mips_pkg;

  localparam int unsigned CtrlWidth = 9;

  // CtrlD bit positions: {ALUOp[1:0], ALUSrc, RegDst, Branch, Jump, RegWrite, MemtoReg, MemWrite}
  localparam int unsigned CTRL_ALUOP_HI = 8;
  localparam int unsigned CTRL_ALUOP_LO = 7;
  localparam int unsigned CTRL_ALUSRC   = 6;
  localparam int unsigned CTRL_REGDST   = 5;
  localparam int unsigned CTRL_BRANCH   = 4;
  localparam int unsigned CTRL_JUMP     = 3;
  localparam int unsigned CTRL_REGWRITE = 2;
  localparam int unsigned CTRL_MEMTOREG = 1;
  localparam int unsigned CTRL_MEMWRITE = 0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Controls consumed in E; Branch/Jump are resolved in D and not carried.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
  } ex_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic [4:0] write_reg;
  } mem_ctrl_t;

endpackage

// File: rtl/hazard_forward_unit.sv
// Forwarding comparators for the E-stage ALU operands and the D-stage branch compare.
module hazard_forward_unit
  import mips_pkg::*;
(
  input  logic [4:0] rs_d_i,
  input  logic [4:0] rt_d_i,
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rt_e_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] write_reg_m_i,
  input  logic       reg_write_w_i,
  input  logic [4:0] write_reg_w_i,
  output logic [1:0] fwd_a_e_o,
  output logic [1:0] fwd_b_e_o,
  output logic       fwd_a_d_o,
  output logic       fwd_b_d_o
);

  // $0 is hardwired, so it never forwards; M wins over W as the younger result.
  function automatic logic [1:0] sel_e(input logic [4:0] src, input logic rw_m,
                                       input logic [4:0] wr_m, input logic rw_w,
                                       input logic [4:0] wr_w);
    if ((src != 5'd0) && (src == wr_m) && rw_m) begin
      return FWD_MEM;
    end else if ((src != 5'd0) && (src == wr_w) && rw_w) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  always_comb begin
    fwd_a_e_o = sel_e(rs_e_i, reg_write_m_i, write_reg_m_i, reg_write_w_i, write_reg_w_i);
    fwd_b_e_o = sel_e(rt_e_i, reg_write_m_i, write_reg_m_i, reg_write_w_i, write_reg_w_i);
    fwd_a_d_o = (rs_d_i != 5'd0) && (rs_d_i == write_reg_m_i) && reg_write_m_i;
    fwd_b_d_o = (rt_d_i != 5'd0) && (rt_d_i == write_reg_m_i) && reg_write_m_i;
  end

endmodule

// File: rtl/hazard_control_pipe.sv
// Control pipeline D->E->M->W with load-use / branch stall detection and forwarding selects.
module hazard_control_pipe
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CtrlWidth-1:0] CtrlD,
  input  logic                 EqualD,
  input  logic [4:0]           RsD,
  input  logic [4:0]           RtD,
  input  logic [4:0]           RdD,
  output logic [3:0]           ExCtrlE,
  output logic                 MemWriteM,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic [4:0]           WriteRegW,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 ForwardAD,
  output logic                 ForwardBD,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 PCSrcD
);

  ex_ctrl_t   ex_q, ex_d;
  logic [4:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d, rd_e_q, rd_e_d;
  mem_ctrl_t  mem_q, mem_d;
  logic       reg_write_w_q, reg_write_w_d;
  logic       mem_to_reg_w_q, mem_to_reg_w_d;
  logic [4:0] write_reg_w_q, write_reg_w_d;

  logic       branch_d, jump_d;
  logic [4:0] write_reg_e;
  logic       lw_stall, branch_stall, stall;
  logic       pc_src;

  always_comb begin
    branch_d     = CtrlD[CTRL_BRANCH];
    jump_d       = CtrlD[CTRL_JUMP];
    write_reg_e  = ex_q.reg_dst ? rd_e_q : rt_e_q;
    lw_stall     = ex_q.mem_to_reg && ((rt_e_q == RsD) || (rt_e_q == RtD));
    branch_stall = branch_d &&
                   ((ex_q.reg_write && ((write_reg_e == RsD) || (write_reg_e == RtD))) ||
                    (mem_q.mem_to_reg && ((mem_q.write_reg == RsD) ||
                                          (mem_q.write_reg == RtD))));
    stall        = lw_stall || branch_stall;
    // Reset gates the decode-driven outputs so nothing escapes while rst_n is low.
    pc_src       = rst_n && branch_d && EqualD && !branch_stall;
  end

  always_comb begin
    ex_d   = '0;
    rs_e_d = '0;
    rt_e_d = '0;
    rd_e_d = '0;
    if (!stall) begin
      ex_d.alu_op     = CtrlD[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
      ex_d.alu_src    = CtrlD[CTRL_ALUSRC];
      ex_d.reg_dst    = CtrlD[CTRL_REGDST];
      ex_d.reg_write  = CtrlD[CTRL_REGWRITE];
      ex_d.mem_to_reg = CtrlD[CTRL_MEMTOREG];
      ex_d.mem_write  = CtrlD[CTRL_MEMWRITE];
      rs_e_d          = RsD;
      rt_e_d          = RtD;
      rd_e_d          = RdD;
    end
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_to_reg = ex_q.mem_to_reg;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.write_reg  = write_reg_e;
    reg_write_w_d    = mem_q.reg_write;
    mem_to_reg_w_d   = mem_q.mem_to_reg;
    write_reg_w_d    = mem_q.write_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q           <= '0;
      rs_e_q         <= '0;
      rt_e_q         <= '0;
      rd_e_q         <= '0;
      mem_q          <= '0;
      reg_write_w_q  <= 1'b0;
      mem_to_reg_w_q <= 1'b0;
      write_reg_w_q  <= '0;
    end else begin
      ex_q           <= ex_d;
      rs_e_q         <= rs_e_d;
      rt_e_q         <= rt_e_d;
      rd_e_q         <= rd_e_d;
      mem_q          <= mem_d;
      reg_write_w_q  <= reg_write_w_d;
      mem_to_reg_w_q <= mem_to_reg_w_d;
      write_reg_w_q  <= write_reg_w_d;
    end
  end

  hazard_forward_unit u_forward (
    .rs_d_i        (RsD),
    .rt_d_i        (RtD),
    .rs_e_i        (rs_e_q),
    .rt_e_i        (rt_e_q),
    .reg_write_m_i (mem_q.reg_write),
    .write_reg_m_i (mem_q.write_reg),
    .reg_write_w_i (reg_write_w_q),
    .write_reg_w_i (write_reg_w_q),
    .fwd_a_e_o     (ForwardAE),
    .fwd_b_e_o     (ForwardBE),
    .fwd_a_d_o     (ForwardAD),
    .fwd_b_d_o     (ForwardBD)
  );

  always_comb begin
    ExCtrlE   = {ex_q.alu_op, ex_q.alu_src, ex_q.reg_dst};
    MemWriteM = mem_q.mem_write;
    RegWriteW = reg_write_w_q;
    MemtoRegW = mem_to_reg_w_q;
    WriteRegW = write_reg_w_q;
    StallF    = stall;
    StallD    = stall;
    PCSrcD    = pc_src;
    FlushD    = rst_n && (pc_src || jump_d) && !stall;
  end

endmodule
